dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 7, data-memory word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with port names as below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 m0_req, m1_req  input  1 each  requester access request; held high with fields stable until the matching gnt.
REQ-007 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  AW each  word address.
REQ-009 m0_wdata, m1_wdata  input  DW each  write data.
REQ-010 m0_gnt, m1_gnt  output  1 each  one-cycle pulse: request accepted and issued to memory this cycle.
REQ-011 m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse: m*_rdata holds read result.
REQ-012 m0_rdata, m1_rdata  output  DW each  registered read data; holds until the next read for that requester completes.
REQ-013 CEN  output  1  memory chip enable, active low.
REQ-014 WEN  output  1  memory write enable, active low.
REQ-015 OEN  output  1  memory output enable, active low.
REQ-016 A  output  AW  memory address.
REQ-017 Data2Mem  output  DW  memory write data.
REQ-018 ReadDataMem  input  DW  memory read data, valid in the cycle after CEN=0 with OEN=0.

Function
REQ-019 All outputs SHALL be driven from registers; the block has no combinational path from inputs to outputs.
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 IDLE transitions: with any req high, go to ACCESS; with none high, stay in IDLE.
REQ-022 ACCESS transitions: on a write, go to IDLE; on a read, go to RESP.
REQ-023 RESP transitions: always go to IDLE.
REQ-024 Arbitration in IDLE:
- a single requesting master wins;
- if both request, the master not granted last wins (round-robin);
- the last_grant register resets to 1, so m0 wins the first tie.
REQ-025 Entering ACCESS:
- pulse the winner's gnt for the ACCESS cycle;
- update last_grant;
- latch the winner's id, we, addr and wdata.
REQ-026 ACCESS outputs:
- CEN=0, A=latched addr;
- write: WEN=0, OEN=1, Data2Mem=latched wdata;
- read: WEN=1, OEN=0.
REQ-027 RESP outputs: CEN=1, WEN=1, OEN=0, A held.
REQ-028 At the edge ending RESP, the winner's rdata SHALL capture ReadDataMem, and the winner's rvalid SHALL pulse in the following (IDLE) cycle.
REQ-029 IDLE outputs: CEN=1, WEN=1, OEN=1; A and Data2Mem hold their last values.
REQ-030 Latency:
- read: req sampled in IDLE cycle N, gnt/ACCESS in N+1, RESP in N+2, rvalid in N+3;
- write: gnt/ACCESS in N+1, memory written at the end of N+1.
REQ-031 Throughput: a new arbitration SHALL occur in the same IDLE cycle as a prior rvalid pulse; one write per 2 cycles and one read per 3 cycles back-to-back.
REQ-032 A req arriving in ACCESS or RESP SHALL be ignored until IDLE; a req dropped before its gnt is not served.
REQ-033 gnt and rvalid SHALL never be high for both masters in the same cycle.
REQ-034 A write SHALL never produce rvalid; the non-winning master's rdata SHALL be unchanged.

Reset
REQ-035 Asserting rst at any time, including mid-ACCESS or mid-RESP, SHALL immediately force:
- state = IDLE, last_grant = 1;
- CEN=WEN=OEN=1, A=0, Data2Mem=0;
- all gnt and rvalid = 0, both rdata = 0.
REQ-036 An access interrupted by reset SHALL be dropped with no rvalid; after reset release, the first arbitration occurs at the first rising edge with rst low.

Verification
REQ-037 m0 write addr 0x05 data 0xDEADBEEF from IDLE -> m0_gnt one cycle later with CEN=0, WEN=0, OEN=1, A=0x05, Data2Mem=0xDEADBEEF; back to IDLE the next cycle; no rvalid.
REQ-038 m1 read addr 0x05, memory returns 0xDEADBEEF -> m1_gnt at N+1 (CEN=0, OEN=0), RESP at N+2, m1_rvalid=1 and m1_rdata=0xDEADBEEF at N+3; m0_rdata unchanged.
REQ-039 m0 and m1 both issue reads, held continuously, from reset -> grant order m0, m1, m0, m1; gnt pulses 3 cycles apart; never both gnt or rvalid high together.
REQ-040 Read rvalid pulse coincides with an IDLE cycle while m0 requests a write -> m0_gnt on the next cycle; effective gap 1 IDLE cycle.
REQ-041 rst asserted during RESP of an m1 read -> outputs reach reset values immediately without a clock edge; m1_rvalid never pulses; after release, a tie grants m0 first.
REQ-042 Random req/we/addr traffic against a 128-word memory model -> every read returns the last data written to that address; every gnt is matched by exactly one memory access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter. A round-robin choice is made in IDLE, and the
// winner is issued to a single-port synchronous SRAM. Every output is driven by a register.
module dmem_arbiter #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] Data2Mem,
  input  logic [DW-1:0] ReadDataMem
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e        r_state, w_state_d;
  // Id of the master granted most recently; reset to 1 so m0 wins the first tie.
  logic          r_last_grant, w_last_grant_d;
  // Winner id and direction of the access in flight.
  logic          r_id, w_id_d;
  logic          r_we, w_we_d;
  logic [1:0]    r_gnt, w_gnt_d;
  logic [1:0]    r_rvalid, w_rvalid_d;
  logic [DW-1:0] r_m0_rdata, w_m0_rdata_d;
  logic [DW-1:0] r_m1_rdata, w_m1_rdata_d;
  logic          r_cen, w_cen_d;
  logic          r_wen, w_wen_d;
  logic          r_oen, w_oen_d;
  logic [AW-1:0] r_a, w_a_d;
  logic [DW-1:0] r_data2mem, w_data2mem_d;

  logic          w_winner;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  // Arbitration: a lone requester wins; on a tie the master not granted last wins.
  assign w_winner    = (m0_req && m1_req) ? ~r_last_grant : m1_req;
  assign w_win_we    = w_winner ? m1_we    : m0_we;
  assign w_win_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_win_wdata = w_winner ? m1_wdata : m0_wdata;

  // Next-state and next-output logic; outputs are registered one cycle ahead of their state.
  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    w_id_d         = r_id;
    w_we_d         = r_we;
    w_gnt_d        = 2'b00;
    w_rvalid_d     = 2'b00;
    w_m0_rdata_d   = r_m0_rdata;
    w_m1_rdata_d   = r_m1_rdata;
    w_cen_d        = 1'b1;
    w_wen_d        = 1'b1;
    w_oen_d        = 1'b1;
    w_a_d          = r_a;
    w_data2mem_d   = r_data2mem;
    unique case (r_state)
      StIdle: begin
        if (m0_req || m1_req) begin
          w_state_d          = StAccess;
          w_last_grant_d     = w_winner;
          w_id_d             = w_winner;
          w_we_d             = w_win_we;
          w_gnt_d[w_winner]  = 1'b1;
          w_cen_d            = 1'b0;
          w_a_d              = w_win_addr;
          if (w_win_we) begin
            w_wen_d      = 1'b0;
            w_data2mem_d = w_win_wdata;
          end else begin
            w_oen_d = 1'b0;
          end
        end
      end
      StAccess: begin
        if (r_we) begin
          w_state_d = StIdle;
        end else begin
          // Keep OEN low while the SRAM drives the read result.
          w_state_d = StResp;
          w_oen_d   = 1'b0;
        end
      end
      StResp: begin
        w_state_d          = StIdle;
        w_rvalid_d[r_id]   = 1'b1;
        if (r_id) begin
          w_m1_rdata_d = ReadDataMem;
        end else begin
          w_m0_rdata_d = ReadDataMem;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Arbitration bookkeeping, master-side and memory-side output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_gnt        <= 2'b00;
      r_rvalid     <= 2'b00;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_cen        <= 1'b1;
      r_wen        <= 1'b1;
      r_oen        <= 1'b1;
      r_a          <= '0;
      r_data2mem   <= '0;
    end else begin
      r_last_grant <= w_last_grant_d;
      r_id         <= w_id_d;
      r_we         <= w_we_d;
      r_gnt        <= w_gnt_d;
      r_rvalid     <= w_rvalid_d;
      r_m0_rdata   <= w_m0_rdata_d;
      r_m1_rdata   <= w_m1_rdata_d;
      r_cen        <= w_cen_d;
      r_wen        <= w_wen_d;
      r_oen        <= w_oen_d;
      r_a          <= w_a_d;
      r_data2mem   <= w_data2mem_d;
    end
  end

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign CEN       = r_cen;
  assign WEN       = r_wen;
  assign OEN       = r_oen;
  assign A         = r_a;
  assign Data2Mem  = r_data2mem;

endmodule
